oled_spi_decoder: RTL

Responder-side SPI receiver and SSD1331 command-stream decoder. It oversamples the OLED PMOD pins (CS, MOSI, SCK, DC, RES) on the system clock and assembles MSB-first bytes. Each byte is classified as opcode, argument, or pixel data and presented on a single-entry valid/ready output. It sits beside the OLED interface as an on-FPGA loopback monitor, and on the bench as its protocol checker.

---
 rtl/oled_spi_decoder_pkg.sv | 78 +++++++
 rtl/oled_spi_decoder_if.sv | 33 +++
 rtl/oled_spi_decoder_spi_byte_rx.sv | 71 +++++++
 rtl/oled_spi_decoder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/oled_spi_decoder_pkg.sv
// Shared types and SSD1331 command table for the OLED SPI loopback decoder.
// arg_len() gives the number of argument bytes that follow each opcode.
package oled_spi_decoder_pkg;

    typedef enum logic [1:0] {
        KIND_OPCODE = 2'b00,
        KIND_ARG    = 2'b01,
        KIND_PIXEL  = 2'b10
    } kind_e;

    typedef enum logic {
        EXPECT_OP,
        ARGS
    } dec_state_e;

    localparam logic [7:0] OP_DRAW_LINE       = 8'h21;
    localparam logic [7:0] OP_DRAW_RECT       = 8'h22;
    localparam logic [7:0] OP_COPY            = 8'h23;
    localparam logic [7:0] OP_DIM_WINDOW      = 8'h24;
    localparam logic [7:0] OP_CLEAR_WINDOW    = 8'h25;
    localparam logic [7:0] OP_FILL            = 8'h26;
    localparam logic [7:0] OP_SCROLL_SETUP    = 8'h27;
    localparam logic [7:0] OP_SCROLL_STOP     = 8'h2E;
    localparam logic [7:0] OP_SCROLL_START    = 8'h2F;
    localparam logic [7:0] OP_SET_COLUMN      = 8'h15;
    localparam logic [7:0] OP_SET_ROW         = 8'h75;
    localparam logic [7:0] OP_CONTRAST_A      = 8'h81;
    localparam logic [7:0] OP_CONTRAST_B      = 8'h82;
    localparam logic [7:0] OP_CONTRAST_C      = 8'h83;
    localparam logic [7:0] OP_MASTER_CURRENT  = 8'h87;
    localparam logic [7:0] OP_PRECHARGE_A     = 8'h8A;
    localparam logic [7:0] OP_PRECHARGE_B     = 8'h8B;
    localparam logic [7:0] OP_PRECHARGE_C     = 8'h8C;
    localparam logic [7:0] OP_REMAP           = 8'hA0;
    localparam logic [7:0] OP_START_LINE      = 8'hA1;
    localparam logic [7:0] OP_DISPLAY_OFFSET  = 8'hA2;
    localparam logic [7:0] OP_DISPLAY_NORMAL  = 8'hA4;
    localparam logic [7:0] OP_DISPLAY_ALL_ON  = 8'hA5;
    localparam logic [7:0] OP_DISPLAY_ALL_OFF = 8'hA6;
    localparam logic [7:0] OP_DISPLAY_INVERSE = 8'hA7;
    localparam logic [7:0] OP_MULTIPLEX       = 8'hA8;
    localparam logic [7:0] OP_DIM_MODE        = 8'hAB;
    localparam logic [7:0] OP_DISPLAY_DIM     = 8'hAC;
    localparam logic [7:0] OP_MASTER_CONFIG   = 8'hAD;
    localparam logic [7:0] OP_DISPLAY_OFF     = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON      = 8'hAF;
    localparam logic [7:0] OP_POWER_SAVE      = 8'hB0;
    localparam logic [7:0] OP_PHASE_PERIOD    = 8'hB1;
    localparam logic [7:0] OP_CLOCK_DIV       = 8'hB3;
    localparam logic [7:0] OP_GRAY_TABLE      = 8'hB8;
    localparam logic [7:0] OP_LINEAR_GRAY     = 8'hB9;
    localparam logic [7:0] OP_PRECHARGE_LEVEL = 8'hBB;
    localparam logic [7:0] OP_VCOMH           = 8'hBE;
    localparam logic [7:0] OP_LOCK            = 8'hFD;

    // Opcodes not listed (including NOPs) take no arguments.
    function automatic logic [5:0] arg_len(input logic [7:0] op);
        case (op)
            OP_GRAY_TABLE:                          arg_len = 6'd32;
            OP_DRAW_RECT:                           arg_len = 6'd10;
            OP_DRAW_LINE:                           arg_len = 6'd7;
            OP_COPY:                                arg_len = 6'd6;
            OP_SCROLL_SETUP, OP_DIM_MODE:           arg_len = 6'd5;
            OP_DIM_WINDOW, OP_CLEAR_WINDOW:         arg_len = 6'd4;
            OP_SET_COLUMN, OP_SET_ROW:              arg_len = 6'd2;
            OP_CONTRAST_A, OP_CONTRAST_B, OP_CONTRAST_C, OP_MASTER_CURRENT,
            OP_PRECHARGE_A, OP_PRECHARGE_B, OP_PRECHARGE_C, OP_REMAP,
            OP_START_LINE, OP_DISPLAY_OFFSET, OP_MULTIPLEX, OP_MASTER_CONFIG,
            OP_POWER_SAVE, OP_PHASE_PERIOD, OP_CLOCK_DIV, OP_PRECHARGE_LEVEL,
            OP_VCOMH, OP_FILL, OP_LOCK:             arg_len = 6'd1;
            OP_DISPLAY_NORMAL, OP_DISPLAY_ALL_ON, OP_DISPLAY_ALL_OFF,
            OP_DISPLAY_INVERSE, OP_DISPLAY_DIM, OP_DISPLAY_OFF, OP_DISPLAY_ON,
            OP_LINEAR_GRAY, OP_SCROLL_STOP, OP_SCROLL_START: arg_len = 6'd0;
            default:                                arg_len = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/oled_spi_decoder_if.sv
// OLED PMOD pins plus the decoded-byte valid/ready output of the SPI decoder.
// master drives the pins and READY; slave is the decoder itself.
interface oled_spi_decoder_if #(
    parameter int N          = 8,
    parameter int MAX_ARGS_W = 6
);
    logic                  i_CS;
    logic                  i_MOSI;
    logic                  i_SCK;
    logic                  i_DC;
    logic                  i_RES;
    logic                  i_READY;
    logic                  o_VALID;
    logic [N-1:0]          o_BYTE;
    logic [1:0]            o_KIND;
    logic [7:0]            o_OPCODE;
    logic [MAX_ARGS_W-1:0] o_ARG_IDX;
    logic                  o_OVERFLOW;
    logic                  o_FRAME_ERR;
    logic                  o_PROTO_ERR;

    modport master (
        output i_CS, i_MOSI, i_SCK, i_DC, i_RES, i_READY,
        input  o_VALID, o_BYTE, o_KIND, o_OPCODE, o_ARG_IDX,
               o_OVERFLOW, o_FRAME_ERR, o_PROTO_ERR
    );

    modport slave (
        input  i_CS, i_MOSI, i_SCK, i_DC, i_RES, i_READY,
        output o_VALID, o_BYTE, o_KIND, o_OPCODE, o_ARG_IDX,
               o_OVERFLOW, o_FRAME_ERR, o_PROTO_ERR
    );
endinterface

// File: rtl/oled_spi_decoder_spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizes the PMOD pins, detects SCK rises
// and assembles MSB-first bytes, flagging frames cut short by CS.
module spi_byte_rx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cs,
    input  logic         mosi,
    input  logic         sck,
    input  logic         dc,
    input  logic         res,
    output logic         byte_valid,
    output logic [N-1:0] byte_data,
    output logic         byte_dc,
    output logic         frame_err,
    output logic         res_active
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Pin order in each stage: {cs, sck, res, dc, mosi}; idle levels reset high
    // so coming out of reset never looks like a select or a clock edge.
    localparam logic [4:0] SYNC_IDLE = 5'b11100;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic                        sck_d;
    logic [CW-1:0]               bit_cnt;
    logic [N-1:0]                shift_q;
    logic                        cs_s, sck_s, res_s, dc_s, mosi_s;
    logic                        sck_rise;

    assign {cs_s, sck_s, res_s, dc_s, mosi_s} = sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign byte_data  = shift_q;
    assign res_active = ~res_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {SYNC_STAGES{SYNC_IDLE}};
            sck_d      <= 1'b1;
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            byte_dc    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], {cs, sck, res, dc, mosi}};
            sck_d      <= sck_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!res_s) begin
                bit_cnt <= '0;
            end else if (cs_s) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
            end else if (sck_rise) begin
                shift_q <= {shift_q[N-2:0], mosi_s};
                if (bit_cnt == CW'(N-1)) begin
                    bit_cnt    <= '0;
                    byte_valid <= 1'b1;
                    byte_dc    <= dc_s;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_decoder.sv
// SSD1331 command-stream decoder: classifies received SPI bytes as opcode,
// argument or pixel data and offers them on a single-entry valid/ready output.
module oled_spi_decoder
    import oled_spi_decoder_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ARGS_W  = 6
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    oled_spi_decoder_if.slave   bus
);

    logic                  rx_valid;
    logic [N-1:0]          rx_byte;
    logic                  rx_dc;
    logic                  rx_frame_err;
    logic                  rx_res;

    dec_state_e            state_q;
    logic [7:0]            opcode_q;
    logic [MAX_ARGS_W-1:0] remaining_q;
    logic [MAX_ARGS_W-1:0] arg_idx_q;

    kind_e                 next_kind;
    logic [7:0]            next_opcode;
    logic [MAX_ARGS_W-1:0] next_idx;
    logic [MAX_ARGS_W-1:0] op_len;
    logic                  can_load;

    spi_byte_rx #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (i_CLK),
        .rst_n      (i_RST_N),
        .cs         (bus.i_CS),
        .mosi       (bus.i_MOSI),
        .sck        (bus.i_SCK),
        .dc         (bus.i_DC),
        .res        (bus.i_RES),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .byte_dc    (rx_dc),
        .frame_err  (rx_frame_err),
        .res_active (rx_res)
    );

    assign can_load = ~bus.o_VALID | bus.i_READY;

    always_comb begin
        next_kind   = KIND_PIXEL;
        next_opcode = 8'h00;
        next_idx    = '0;
        op_len      = MAX_ARGS_W'(arg_len(rx_byte[7:0]));
        if (!rx_dc) begin
            if (state_q == EXPECT_OP) begin
                next_kind   = KIND_OPCODE;
                next_opcode = rx_byte[7:0];
            end else begin
                next_kind   = KIND_ARG;
                next_opcode = opcode_q;
                next_idx    = arg_idx_q + MAX_ARGS_W'(1);
            end
        end
    end

    // The decoder advances on every completed byte, even one dropped for
    // overflow, so the command stream stays aligned with the master.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q         <= EXPECT_OP;
            opcode_q        <= 8'h00;
            remaining_q     <= '0;
            arg_idx_q       <= '0;
            bus.o_VALID     <= 1'b0;
            bus.o_BYTE      <= '0;
            bus.o_KIND      <= 2'b00;
            bus.o_OPCODE    <= 8'h00;
            bus.o_ARG_IDX   <= '0;
            bus.o_OVERFLOW  <= 1'b0;
            bus.o_FRAME_ERR <= 1'b0;
            bus.o_PROTO_ERR <= 1'b0;
        end else begin
            if (rx_valid) begin
                if (can_load) begin
                    bus.o_VALID   <= 1'b1;
                    bus.o_BYTE    <= rx_byte;
                    bus.o_KIND    <= next_kind;
                    bus.o_OPCODE  <= next_opcode;
                    bus.o_ARG_IDX <= next_idx;
                end else begin
                    bus.o_OVERFLOW <= 1'b1;
                end

                if (rx_dc) begin
                    if (state_q == ARGS) begin
                        bus.o_PROTO_ERR <= 1'b1;
                        state_q         <= EXPECT_OP;
                    end
                end else if (state_q == EXPECT_OP) begin
                    opcode_q    <= rx_byte[7:0];
                    remaining_q <= op_len;
                    arg_idx_q   <= '0;
                    if (op_len != '0) state_q <= ARGS;
                end else begin
                    arg_idx_q   <= next_idx;
                    remaining_q <= remaining_q - MAX_ARGS_W'(1);
                    if (remaining_q == MAX_ARGS_W'(1)) state_q <= EXPECT_OP;
                end
            end else if (bus.o_VALID && bus.i_READY) begin
                bus.o_VALID <= 1'b0;
            end

            if (rx_frame_err) bus.o_FRAME_ERR <= 1'b1;
            if (rx_res) state_q <= EXPECT_OP;
        end
    end

endmodule
